// File: rtl/engine_pkg.sv
// Shared encodings and saturation helper for the burst MAC/pool engine.
// sat_clip works on a wide signed carrier so one function covers every width.
package engine_pkg;

  typedef enum logic [1:0] {
    MODE_MAC = 2'd0,
    MODE_MAX = 2'd1,
    MODE_SUM = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_D = 3'd1,
    LOAD_W = 3'd2,
    WB     = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int SAT_W = 128;
  typedef logic signed [SAT_W-1:0] wide_t;

  // Clamp v into the signed range of a w-bit word (w < SAT_W).
  function automatic wide_t sat_clip(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_burst_engine_if.sv
// Control, operand and result streams of the burst engine.
// master = csb/dma side, slave = engine.
interface mac_burst_engine_if #(
  parameter int DW = 16,
  parameter int CW = 32
);
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] op_num;
  logic [4:0]    avg_shift;
  logic [DW-1:0] in_data;
  logic          in_data_valid;
  logic          in_data_ready;
  logic [DW-1:0] in_wgt;
  logic          in_wgt_valid;
  logic          in_wgt_ready;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, op_num, avg_shift,
    output in_data, in_data_valid, in_wgt, in_wgt_valid, res_ready,
    input  in_data_ready, in_wgt_ready, res_data, res_valid, busy, done
  );

  modport slave (
    input  start, mode, op_num, avg_shift,
    input  in_data, in_data_valid, in_wgt, in_wgt_valid, res_ready,
    output in_data_ready, in_wgt_ready, res_data, res_valid, busy, done
  );
endinterface

// File: rtl/mac_burst_engine_lane_acc.sv
// One accumulator lane: saturating MAC / running max / saturating sum.
// Update lands one cycle after en; result is combinational from the accumulator.
module lane_acc
  import engine_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 40,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  mode_e                mode,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic [4:0]           avg_shift,
  output logic signed [DW-1:0] result
);

  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_nxt;
  logic signed [AW-1:0]   init_val;
  logic signed [2*DW-1:0] prod;
  wide_t                  acc_w;
  wide_t                  opnd_w;
  wide_t                  conv_w;

  assign prod     = (2*DW)'(a) * (2*DW)'(b);
  assign acc_w    = wide_t'(acc);
  // MAX starts from the most negative DW value so any operand wins the first compare.
  assign init_val = (mode == MODE_MAX) ? AW'($signed({1'b1, {(DW-1){1'b0}}})) : '0;

  always_comb begin
    opnd_w  = (mode == MODE_MAX || mode == MODE_SUM) ? wide_t'(a) : wide_t'(prod);
    acc_nxt = acc;
    if (mode == MODE_MAX) begin
      if (opnd_w > acc_w) acc_nxt = AW'(opnd_w);
    end else begin
      acc_nxt = AW'(sat_clip(acc_w + opnd_w, AW));
    end
  end

  always_comb begin
    conv_w = acc_w >>> FRAC;
    if (mode == MODE_SUM) conv_w = acc_w >>> avg_shift;
    if (mode == MODE_MAX) result = acc[DW-1:0];
    else                  result = DW'(sat_clip(conv_w, DW));
  end

  always_ff @(posedge clk) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= init_val;
    else if (en)    acc <= acc_nxt;
  end

endmodule

// File: rtl/mac_burst_engine.sv
// Lane-array engine for conv (MAC), maxpool and avepool over op_num rounds.
// Readies depend on state only; results drain lane 0..LANES-1 under full backpressure.
module mac_burst_engine
  import engine_pkg::*;
#(
  parameter int LANES = 16,
  parameter int DW    = 16,
  parameter int AW    = 40,
  parameter int CW    = 32,
  parameter int FRAC  = 8
) (
  input  logic              clk,
  input  logic              rst,
  mac_burst_engine_if.slave bus
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  state_e               state;
  state_e               state_nxt;
  mode_e                mode_q;
  mode_e                mode_in;
  mode_e                lane_mode;
  logic [CW-1:0]        op_num_q;
  logic [CW-1:0]        round_cnt;
  logic [4:0]           shift_q;
  logic [IW-1:0]        lane_idx;
  logic signed [DW-1:0] d_reg;
  logic signed [DW-1:0] opnd_a;
  logic signed [DW-1:0] lane_res [LANES];
  logic                 start_ok;
  logic                 beat;
  logic                 wb_fire;
  logic                 last_lane;
  logic                 round_end;

  always_comb begin
    case (bus.mode)
      2'd1:    mode_in = MODE_MAX;
      2'd2:    mode_in = MODE_SUM;
      default: mode_in = MODE_MAC;
    endcase
  end

  assign last_lane = (lane_idx == IW'(LANES - 1));
  assign round_end = last_lane && ((round_cnt + CW'(1)) == op_num_q);
  // Lanes see the incoming mode during IDLE so the start-cycle clear picks the right init value.
  assign lane_mode = (state == IDLE) ? mode_in : mode_q;
  assign opnd_a    = (mode_q == MODE_MAC) ? d_reg : bus.in_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    start_ok          = 1'b0;
    beat              = 1'b0;
    wb_fire           = 1'b0;
    bus.in_data_ready = 1'b0;
    bus.in_wgt_ready  = 1'b0;
    bus.res_valid     = 1'b0;
    bus.busy          = 1'b1;
    bus.done          = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          start_ok  = 1'b1;
          state_nxt = (bus.op_num == '0) ? WB : LOAD_D;
        end
      end
      LOAD_D: begin
        bus.in_data_ready = 1'b1;
        if (bus.in_data_valid) begin
          if (mode_q == MODE_MAC) begin
            state_nxt = LOAD_W;
          end else begin
            beat = 1'b1;
            if (round_end) state_nxt = WB;
          end
        end
      end
      LOAD_W: begin
        bus.in_wgt_ready = 1'b1;
        if (bus.in_wgt_valid) begin
          beat = 1'b1;
          if (round_end)      state_nxt = WB;
          else if (last_lane) state_nxt = LOAD_D;
        end
      end
      WB: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          wb_fire = 1'b1;
          if (last_lane) state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_MAC;
      op_num_q  <= '0;
      shift_q   <= '0;
      round_cnt <= '0;
      lane_idx  <= '0;
      d_reg     <= '0;
    end else begin
      if (start_ok) begin
        mode_q    <= mode_in;
        op_num_q  <= bus.op_num;
        shift_q   <= bus.avg_shift;
        round_cnt <= '0;
        lane_idx  <= '0;
      end
      if (state == LOAD_D && bus.in_data_valid && mode_q == MODE_MAC) d_reg <= bus.in_data;
      if (beat || wb_fire) lane_idx <= last_lane ? '0 : lane_idx + IW'(1);
      if (beat && last_lane) round_cnt <= round_cnt + CW'(1);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_acc #(
      .DW  (DW),
      .AW  (AW),
      .FRAC(FRAC)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clear    (start_ok),
      .en       (beat && (lane_idx == IW'(g))),
      .mode     (lane_mode),
      .a        (opnd_a),
      .b        (bus.in_wgt),
      .avg_shift(shift_q),
      .result   (lane_res[g])
    );
  end

  assign bus.res_data = (state == WB) ? lane_res[lane_idx] : '0;

endmodule

// File: tb/tb_mac_burst_engine.sv
// Bench for mac_burst_engine: directed vector table, hand sequences, random ops vs a reference model.
module tb_mac_burst_engine;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_burst_engine_if #(.DW(16), .CW(32)) ifc ();

  mac_burst_engine #(
    .LANES(L), .DW(16), .AW(40), .CW(32), .FRAC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct packed {
    logic [1:0]        md;
    logic [3:0]        opn;
    logic [4:0]        sh;
    logic [15:0][15:0] d;
    logic [15:0][15:0] w;
    logic [3:0][15:0]  r;
  } vec_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          dq[$];
  int          wq[$];
  logic [15:0] got[$];
  logic [15:0] expq[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int rnd16();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 600)) - 300;
    return int'($signed(16'($urandom)));
  endfunction

  // Reference: per-lane accumulation straight from the operation rules.
  task automatic model(input int md, input int opn, input int sh);
    longint acc[L];
    expq.delete();
    for (int l = 0; l < L; l++) acc[l] = (md == 1) ? -32768 : 0;
    for (int r = 0; r < opn; r++) begin
      for (int l = 0; l < L; l++) begin
        case (md)
          1:       if (dq[r*L+l] > acc[l]) acc[l] = dq[r*L+l];
          2:       acc[l] = clampw(acc[l] + dq[r*L+l], 40);
          default: acc[l] = clampw(acc[l] + longint'(dq[r]) * wq[r*L+l], 40);
        endcase
      end
    end
    for (int l = 0; l < L; l++) begin
      case (md)
        1:       expq.push_back(16'(acc[l]));
        2:       expq.push_back(16'(clampw(acc[l] >>> sh, 16)));
        default: expq.push_back(16'(clampw(acc[l] >>> 8, 16)));
      endcase
    end
  endtask

  task automatic run_op(input string tag, input int md, input int opn, input int sh,
                        input int drop, input int bp, input bit noise, input int abort_after,
                        output int lat);
    int nd, nw, di, wi, cyc, wr_seen, hold, beats;
    bit fin, prev_stall, pool;
    logic [15:0] prev_d;
    pool = (md == 1 || md == 2);
    nd = pool ? opn * L : opn;
    nw = pool ? 0 : opn * L;
    di = 0; wi = 0; cyc = 0; wr_seen = 0; hold = 0; beats = 0;
    fin = 1'b0; prev_stall = 1'b0; prev_d = '0; lat = -1;
    got.delete();
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      if (prev_stall) check({tag, " res_stable"}, ifc.res_data, prev_d);
      if (lat >= 0) begin
        check({tag, " done_one_cycle"}, ifc.done, 0);
        check({tag, " busy_after_done"}, ifc.busy, 0);
        fin = 1'b1;
      end else begin
        if (ifc.done) begin
          lat = cyc;
          check({tag, " busy_in_done"}, ifc.busy, 1);
        end
        if (ifc.in_wgt_ready) wr_seen++;
        if (abort_after >= 0 && beats == abort_after) begin
          check({tag, " abort_in_loadw"}, ifc.in_wgt_ready, 1);
          rst = 1'b1;
          ifc.start = 1'b0; ifc.in_data_valid = 1'b0; ifc.in_wgt_valid = 1'b0;
          @(negedge clk);
          check({tag, " rst_res_data"}, ifc.res_data, 0);
          check({tag, " rst_res_valid"}, ifc.res_valid, 0);
          check({tag, " rst_data_ready"}, ifc.in_data_ready, 0);
          check({tag, " rst_wgt_ready"}, ifc.in_wgt_ready, 0);
          check({tag, " rst_busy"}, ifc.busy, 0);
          check({tag, " rst_done"}, ifc.done, 0);
          rst = 1'b0;
          return;
        end
        ifc.start = (cyc == 0);
        if (cyc == 0) begin
          ifc.mode = 2'(md); ifc.op_num = 32'(opn); ifc.avg_shift = 5'(sh);
        end else if (noise) begin
          ifc.mode = 2'($urandom); ifc.op_num = $urandom_range(0, 6); ifc.avg_shift = 5'($urandom);
          ifc.start = (ifc.in_data_ready || ifc.in_wgt_ready || ifc.res_valid) && ($urandom_range(0, 2) == 0);
        end
        ifc.in_data_valid = (di < nd) && ($urandom_range(0, 99) >= drop);
        ifc.in_data       = (di < nd) ? 16'(dq[di]) : 16'($urandom);
        ifc.in_wgt_valid  = (wi < nw) && ($urandom_range(0, 99) >= drop);
        ifc.in_wgt        = (wi < nw) ? 16'(wq[wi]) : 16'($urandom);
        case (bp)
          1:       ifc.res_ready = ($urandom_range(0, 9) < 7);
          2:       begin
                     ifc.res_ready = !(got.size() == 2 && hold < 10);
                     if (!ifc.res_ready) hold++;
                   end
          default: ifc.res_ready = 1'b1;
        endcase
        if (ifc.in_data_valid && ifc.in_data_ready) begin di++; beats++; end
        if (ifc.in_wgt_valid && ifc.in_wgt_ready) begin wi++; beats++; end
        if (ifc.res_valid && ifc.res_ready) got.push_back(ifc.res_data);
        prev_stall = ifc.res_valid && !ifc.res_ready;
        prev_d     = ifc.res_data;
        cyc++;
      end
    end
    ifc.start = 1'b0; ifc.in_data_valid = 1'b0; ifc.in_wgt_valid = 1'b0; ifc.res_ready = 1'b0;
    check({tag, " finished"}, fin, 1);
    check({tag, " data_beats"}, di, nd);
    check({tag, " wgt_beats"}, wi, nw);
    if (pool) check({tag, " wgt_ready_seen"}, wr_seen, 0);
    check({tag, " n_results"}, got.size(), L);
    for (int l = 0; l < L; l++)
      if (l < got.size() && l < expq.size())
        check($sformatf("%s res%0d", tag, l), got[l], expq[l]);
  endtask

  initial begin
    vec_t        vt[8];
    int          mx[12] = '{5, -3, 7, 0, 2, 9, -1, 0, -8, 1, 4, 0};
    int          lat;
    int          md, opn;
    logic [15:0] first[$];

    rst = 1'b1;
    ifc.start = 1'b0; ifc.mode = '0; ifc.op_num = '0; ifc.avg_shift = '0;
    ifc.in_data = '0; ifc.in_data_valid = 1'b0; ifc.in_wgt = '0; ifc.in_wgt_valid = 1'b0;
    ifc.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset res_data", ifc.res_data, 0);
    check("reset res_valid", ifc.res_valid, 0);
    check("reset data_ready", ifc.in_data_ready, 0);
    check("reset wgt_ready", ifc.in_wgt_ready, 0);
    check("reset busy", ifc.busy, 0);
    check("reset done", ifc.done, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) vt[i] = '0;
    vt[0].md = 0; vt[0].opn = 2; vt[0].d[0] = 16'h0100; vt[0].d[1] = 16'h0200;
    for (int k = 0; k < 8; k++) vt[0].w[k] = 16'(256 * (k % 4 + 1));
    vt[0].r = {16'h0C00, 16'h0900, 16'h0600, 16'h0300};
    vt[1].md = 1; vt[1].opn = 3;
    for (int k = 0; k < 12; k++) vt[1].d[k] = 16'(mx[k]);
    vt[1].r = {16'd0, 16'd7, 16'd9, 16'd5};
    vt[2].md = 2; vt[2].opn = 4; vt[2].sh = 2;
    for (int k = 0; k < 16; k++) vt[2].d[k] = 16'h0040;
    vt[2].r = {4{16'h0040}};
    vt[3].md = 1; vt[3].opn = 0; vt[3].r = {4{16'h8000}};
    vt[4].md = 2; vt[4].opn = 4; vt[4].sh = 0;
    for (int k = 0; k < 16; k++) vt[4].d[k] = 16'h7FFF;
    vt[4].r = {4{16'h7FFF}};
    vt[5].md = 0; vt[5].opn = 2; vt[5].d[0] = 16'h7FFF; vt[5].d[1] = 16'h7FFF;
    for (int k = 0; k < 8; k++) vt[5].w[k] = (k % 4 == 3) ? 16'h8000 : 16'h7FFF;
    vt[5].r = {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vt[6].md = 3; vt[6].opn = 1; vt[6].d[0] = 16'hFF00;
    vt[6].w[0] = 16'h7FFF; vt[6].w[1] = 16'h8000; vt[6].w[2] = 16'h0080; vt[6].w[3] = 16'hFF80;
    vt[6].r = {16'h0080, 16'hFF80, 16'h7FFF, 16'h8001};
    vt[7].md = 2; vt[7].opn = 2; vt[7].sh = 1;
    vt[7].d[0] = 16'hFFFD; vt[7].d[1] = 16'd100; vt[7].d[2] = 16'h8000; vt[7].d[3] = 16'd1;
    vt[7].d[4] = 16'hFFFC; vt[7].d[5] = 16'd100; vt[7].d[6] = 16'h8000; vt[7].d[7] = 16'd0;
    vt[7].r = {16'h0000, 16'h8000, 16'h0064, 16'hFFFC};

    for (int i = 0; i < 8; i++) begin
      dq.delete(); wq.delete(); expq.delete();
      for (int k = 0; k < 16; k++) begin
        dq.push_back(int'($signed(vt[i].d[k])));
        wq.push_back(int'($signed(vt[i].w[k])));
      end
      for (int l = 0; l < L; l++) expq.push_back(vt[i].r[l]);
      run_op($sformatf("vec%0d", i), int'(vt[i].md), int'(vt[i].opn), int'(vt[i].sh), 0, 0, 1'b0, -1, lat);
      md  = int'(vt[i].md);
      opn = int'(vt[i].opn);
      check($sformatf("vec%0d latency", i), lat,
            1 + L + ((md == 1 || md == 2) ? opn * L : opn * (1 + L)));
    end

    // Backpressure: 10-cycle result stall plus valid drops, then the same op unstalled.
    dq.delete(); wq.delete();
    for (int k = 0; k < 16; k++) begin dq.push_back(rnd16()); wq.push_back(rnd16()); end
    model(0, 3, 0);
    run_op("bp_stall", 0, 3, 0, 40, 2, 1'b0, -1, lat);
    first = got;
    run_op("bp_clean", 0, 3, 0, 0, 0, 1'b0, -1, lat);
    for (int l = 0; l < L; l++)
      if (l < first.size() && l < got.size())
        check($sformatf("bp_same res%0d", l), first[l], got[l]);

    // Start pulses and input churn while busy must not disturb a running op.
    model(0, 2, 0);
    run_op("start_ignored", 0, 2, 0, 20, 1, 1'b1, -1, lat);

    // Reset inside LOAD_W of the second round, then a clean op_num=1 MAC.
    run_op("abort", 0, 2, 0, 0, 0, 1'b0, 7, lat);
    dq.delete(); wq.delete();
    for (int k = 0; k < 16; k++) begin dq.push_back(rnd16()); wq.push_back(rnd16()); end
    model(0, 1, 0);
    run_op("post_rst", 0, 1, 0, 0, 0, 1'b0, -1, lat);

    for (int t = 0; t < 24; t++) begin
      int rmd, ropn, rsh;
      rmd  = $urandom_range(0, 3);
      ropn = $urandom_range(0, 4);
      rsh  = $urandom_range(0, 7);
      dq.delete(); wq.delete();
      for (int k = 0; k < 16; k++) begin dq.push_back(rnd16()); wq.push_back(rnd16()); end
      model(rmd, ropn, rsh);
      run_op($sformatf("rnd%0d", t), rmd, ropn, rsh, $urandom_range(0, 50),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mac_burst_engine.md
Name: mac_burst_engine

Overview:
- Parametrised successor to the fixed 16-lane conv/pool engine: one array of LANES generic lanes serves multiply-accumulate (conv), running-max (maxpool) and running-sum (avepool).
- Mode is selected per operation.
- Operands arrive on valid/ready streams from the DMA-fed FIFOs.
- Results leave on a valid/ready stream to the result FIFO with full backpressure.
- Sits between csb (start/mode/op_num) and the dma/fifo layer.

Parameters:
LANES, 16, number of parallel lanes, range 1..64
DW, 16, signed data/weight/result width (two's complement fixed point)
AW, 40, signed accumulator width; must be >= 2*DW+clog2(max op_num)
CW, 32, width of op_num round counter
FRAC, 8, fractional bits dropped from MAC products on writeback

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  0=MAC, 1=MAX, 2=SUM, 3=reserved (treated as MAC); latched on start
op_num  in  CW  rounds to accumulate; latched on start
avg_shift  in  5  right shift applied to SUM results; latched on start
in_data  in  DW  data operand
in_data_valid  in  1  data beat available
in_data_ready  out  1  engine accepts data beat
in_wgt  in  DW  weight operand
in_wgt_valid  in  1  weight beat available
in_wgt_ready  out  1  engine accepts weight beat
res_data  out  DW  result word, lane order 0..LANES-1
res_valid  out  1  result word valid
res_ready  in  1  result sink ready
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after last result handshake

Behaviour:
- Reset (sync, any state incl. mid-op) forces next cycle: state IDLE, counters 0, accumulators cleared, all outputs 0 (res_data=0, readies=0, busy=0, done=0).
- States: IDLE, LOAD_D, LOAD_W, WB, DONE.
- IDLE:
  - start=1 latches mode/op_num/avg_shift, clears accumulators to init value (0 for MAC/SUM, -2^(DW-1) for MAX), busy<=1.
  - op_num=0 -> WB, initial values are written back; else -> LOAD_D.
- MAC round:
  - LOAD_D takes one data beat (in_data_ready=1 only here), holds it in an operand register, -> LOAD_W.
  - LOAD_W takes LANES weight beats; beat i updates lane i: acc_i += d*w_i (full 2*DW product, sign-extended to AW, saturating add).
  - After beat LANES-1: round counter +1; if counter==op_num -> WB, else -> LOAD_D.
- MAX/SUM round:
  - Stays in LOAD_D for LANES data beats; beat i updates lane i (MAX: acc_i=max(acc_i,d); SUM: saturating add).
  - in_wgt_ready=0 throughout. Round end as in MAC.
- Handshake:
  - A beat transfers on valid&&ready in the same cycle.
  - ready is a registered function of state only, never of valid; stalls on valid=0 are unlimited.
  - Lane index counter wraps LANES-1 -> 0 at round end.
- WB:
  - res_valid=1; res_data = lane[wb_idx] converted: MAC = sat_DW(acc>>>FRAC), SUM = sat_DW(acc>>>avg_shift), MAX = acc[DW-1:0].
  - wb_idx advances only on res_valid&&res_ready.
  - res_data stays stable while res_valid&&!res_ready.
  - After handshake of lane LANES-1 -> DONE.
- DONE: done=1 for one cycle, busy<=0, -> IDLE. Back-to-back start accepted in the following IDLE cycle.
- Latency: MAC op = op_num*(1+LANES) accepted beats + LANES result beats + 1 DONE cycle, with no stalls.
- Saturation: results clamp to [-2^(DW-1), 2^(DW-1)-1]; the accumulator clamps to AW limits and never wraps.
- start outside IDLE is ignored; changes on mode/op_num inputs mid-op have no effect.

Decomposition:
- Shared package engine_pkg: mode encodings (MODE_MAC, MODE_MAX, MODE_SUM), state encodings, sat helper function (AW->DW, AW add).
- Sub-module lane_acc: one lane; en, mode, operand a, operand b, clear/init inputs; holds acc; outputs converted result. Instantiated LANES times by generate.
- Top holds FSM, counters, operand register, writeback mux.

Test Plan:
- LANES=4, MAC, op_num=2, FRAC=8, data {0x0100, 0x0200}, weights {0x0100,0x0200,0x0300,0x0400} per round -> results 0x0300, 0x0600, 0x0900, 0x0C00; done pulse exactly once.
- LANES=4, MAX, op_num=3, data rounds {5,-3,7,0},{2,9,-1,0},{-8,1,4,0} -> results 5, 9, 7, 0; in_wgt_ready never asserted.
- LANES=4, SUM, op_num=4, avg_shift=2, every beat 0x0040 -> every result 0x0040; separately, DW=16 with 0x7FFF products accumulated to overflow with FRAC=0 -> results 0x7FFF.
- Backpressure: hold res_ready=0 for 10 cycles mid-WB, randomly drop in_*_valid -> res_data stable while stalled, results identical to the unstalled run, no beat lost or duplicated.
- op_num=0 in MAX mode -> 4 results of 0x8000 with no input beats consumed; start pulsed during LOAD_W is ignored.
- rst asserted during LOAD_W of round 1, then a fresh op_num=1 MAC -> all outputs 0 the cycle after rst; new results reflect only post-reset beats.
